// File: rtl/money_display_scan.sv
// Converts the vending FSM amounts and state code to BCD and drives an
// 8-digit common-anode 7-segment display by time-multiplexed scanning.
module money_display_scan #(
    parameter int SCAN_DIV = 100000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [6:0] need_money,
    input  logic [7:0] input_money,
    input  logic [7:0] change_money,
    input  logic [5:0] state_in,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        CAPTURE,
        CONV,
        COMMIT
    } conv_state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Three digits {hundreds, tens, units} with leading zeros blanked.
    function automatic logic [20:0] group3(input logic [11:0] b);
        logic [6:0] h;
        logic [6:0] t;
        logic [6:0] u;
        h = (b[11:8] == 4'd0) ? SEG_BLANK : seg7(b[11:8]);
        t = (b[11:4] == 8'd0) ? SEG_BLANK : seg7(b[7:4]);
        u = seg7(b[3:0]);
        return {h, t, u};
    endfunction

    conv_state_t cstate;
    logic [7:0]  snap_input;
    logic [7:0]  snap_change;
    logic [5:0]  snap_state;
    logic [7:0]  shreg;
    logic [11:0] bcd;
    logic [1:0]  vidx;
    logic [2:0]  step;
    logic [11:0] bcd_need;
    logic [11:0] bcd_input;
    logic [11:0] bcd_change;

    logic [6:0]  dig      [8];
    logic [6:0]  next_dig [8];

    logic [11:0] bcd_adj;
    logic [11:0] bcd_shift;

    always_comb begin
        bcd_adj = bcd;
        for (int n = 0; n < 3; n++) begin
            if (bcd[n*4 +: 4] >= 4'd5) begin
                bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
            end
        end
        bcd_shift = {bcd_adj[10:0], shreg[7]};
    end

    logic        valid_state;
    logic        show_input;
    logic        show_change;
    logic [20:0] need_grp;
    logic [20:0] money_grp;

    always_comb begin
        valid_state = $onehot(snap_state);
        show_input  = |snap_state[3:1];
        show_change = |snap_state[5:4];
        need_grp    = group3(bcd_need);
        money_grp   = show_change ? group3(bcd_change) : group3(bcd_input);
        for (int k = 0; k < 8; k++) begin
            next_dig[k] = SEG_BLANK;
        end
        if (!valid_state) begin
            next_dig[4] = SEG_DASH;
            next_dig[3] = SEG_DASH;
        end else begin
            // Hex nibbles of the one-hot code read as decimal digits.
            next_dig[4] = seg7({2'b00, snap_state[5:4]});
            next_dig[3] = seg7(snap_state[3:0]);
            if (show_input || show_change) begin
                next_dig[7] = need_grp[20:14];
                next_dig[6] = need_grp[13:7];
                next_dig[5] = need_grp[6:0];
                next_dig[2] = money_grp[20:14];
                next_dig[1] = money_grp[13:7];
                next_dig[0] = money_grp[6:0];
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cstate      <= CAPTURE;
            snap_input  <= 8'd0;
            snap_change <= 8'd0;
            snap_state  <= 6'd0;
            shreg       <= 8'd0;
            bcd         <= 12'd0;
            vidx        <= 2'd0;
            step        <= 3'd0;
            bcd_need    <= 12'd0;
            bcd_input   <= 12'd0;
            bcd_change  <= 12'd0;
            for (int k = 0; k < 8; k++) begin
                dig[k] <= SEG_BLANK;
            end
        end else begin
            case (cstate)
                CAPTURE: begin
                    snap_input  <= input_money;
                    snap_change <= change_money;
                    snap_state  <= state_in;
                    shreg       <= {1'b0, need_money};
                    bcd         <= 12'd0;
                    vidx        <= 2'd0;
                    step        <= 3'd0;
                    cstate      <= CONV;
                end
                CONV: begin
                    if (step == 3'd7) begin
                        bcd  <= 12'd0;
                        step <= 3'd0;
                        vidx <= vidx + 2'd1;
                        case (vidx)
                            2'd0: begin
                                bcd_need <= bcd_shift;
                                shreg    <= snap_input;
                            end
                            2'd1: begin
                                bcd_input <= bcd_shift;
                                shreg     <= snap_change;
                            end
                            default: begin
                                bcd_change <= bcd_shift;
                                shreg      <= 8'd0;
                                cstate     <= COMMIT;
                            end
                        endcase
                    end else begin
                        bcd   <= bcd_shift;
                        shreg <= {shreg[6:0], 1'b0};
                        step  <= step + 3'd1;
                    end
                end
                default: begin
                    for (int k = 0; k < 8; k++) begin
                        dig[k] <= next_dig[k];
                    end
                    cstate <= CAPTURE;
                end
            endcase
        end
    end

    logic [CW-1:0] cnt;
    logic [2:0]    idx;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
            idx <= 3'd0;
            an  <= 8'hFF;
            seg <= SEG_BLANK;
        end else begin
            if (cnt == CW'(SCAN_DIV - 1)) begin
                cnt <= '0;
                idx <= idx + 3'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
            an  <= ~(8'd1 << idx);
            seg <= dig[idx];
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_money_display_scan.sv
// Directed bench for money_display_scan: reset, decoding of each state,
// value limits, scan order and snapshot integrity.
module tb_money_display_scan;

    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] DS = 7'h3F;
    localparam logic [6:0] S0 = 7'h40;
    localparam logic [6:0] S1 = 7'h79;
    localparam logic [6:0] S2 = 7'h24;
    localparam logic [6:0] S3 = 7'h30;
    localparam logic [6:0] S4 = 7'h19;
    localparam logic [6:0] S5 = 7'h12;
    localparam logic [6:0] S7 = 7'h78;
    localparam logic [6:0] S8 = 7'h00;
    localparam logic [6:0] S9 = 7'h10;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [6:0] need_money;
    logic [7:0] input_money;
    logic [7:0] change_money;
    logic [5:0] state_in;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    int total;
    int bad;

    money_display_scan #(.SCAN_DIV(4)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .need_money  (need_money),
        .input_money (input_money),
        .change_money(change_money),
        .state_in    (state_in),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic set_in(input logic [5:0] st, input int nd,
                          input int im, input int cm);
        state_in     = st;
        need_money   = 7'(nd);
        input_money  = 8'(im);
        change_money = 8'(cm);
    endtask

    // Returns with the clock low; the next rising edge is post-reset edge 1.
    task automatic reset_dut();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic read_display(output logic [55:0] d);
        logic [6:0] dd [8];
        for (int k = 0; k < 8; k++) dd[k] = 'x;
        repeat (40) begin
            @(posedge sys_clk);
            #1;
            for (int k = 0; k < 8; k++) begin
                if (an == ~(8'd1 << k)) dd[k] = seg;
            end
        end
        d = {dd[7], dd[6], dd[5], dd[4], dd[3], dd[2], dd[1], dd[0]};
    endtask

    task automatic show(input logic [5:0] st, input int nd, input int im,
                        input int cm, output logic [55:0] d);
        set_in(st, nd, im, cm);
        repeat (60) @(posedge sys_clk);
        read_display(d);
    endtask

    task automatic test_reset();
        int blank_bad;
        set_in(6'h08, 23, 150, 0);
        repeat (50) @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        total++;
        if (an !== 8'hFF) begin
            bad++;
            $display("FAIL reset_an got=%h want=ff", an);
        end
        total++;
        if (seg !== BL) begin
            bad++;
            $display("FAIL reset_seg got=%h want=%h", seg, BL);
        end
        total++;
        if (dp !== 1'b1) begin
            bad++;
            $display("FAIL reset_dp got=%b want=1", dp);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        blank_bad = 0;
        for (int e = 1; e <= 26; e++) begin
            @(posedge sys_clk);
            #1;
            if (e == 1) begin
                total++;
                if (an !== 8'hFE) begin
                    bad++;
                    $display("FAIL first_an got=%h want=fe", an);
                end
            end
            if (seg !== BL) blank_bad++;
        end
        total++;
        if (blank_bad != 0) begin
            bad++;
            $display("FAIL precommit_blank got=%0d nonblank want=0",
                     blank_bad);
        end
        repeat (7) @(posedge sys_clk);
        #1;
        total++;
        if (an !== 8'hFE || seg !== S0) begin
            bad++;
            $display("FAIL first_commit got=%h/%h want=fe/%h", an, seg, S0);
        end
    endtask

    task automatic test_payment();
        logic [55:0] d;
        logic [55:0] x;
        show(6'h08, 23, 150, 9, d);
        x = {BL, S2, S3, S0, S8, S1, S5, S0};
        total++;
        if (d !== x) begin
            bad++;
            $display("FAIL payment got=%h want=%h", d, x);
        end
    endtask

    task automatic test_change();
        logic [55:0] d;
        logic [55:0] x;
        show(6'h10, 45, 200, 7, d);
        x = {BL, S4, S5, S1, S0, BL, BL, S7};
        total++;
        if (d !== x) begin
            bad++;
            $display("FAIL change7 got=%h want=%h", d, x);
        end
        show(6'h10, 45, 200, 0, d);
        x = {BL, S4, S5, S1, S0, BL, BL, S0};
        total++;
        if (d !== x) begin
            bad++;
            $display("FAIL change0 got=%h want=%h", d, x);
        end
    endtask

    task automatic test_limits();
        logic [55:0] d;
        logic [55:0] x;
        show(6'h04, 127, 255, 3, d);
        x = {S1, S2, S7, S0, S4, S2, S5, S5};
        total++;
        if (d !== x) begin
            bad++;
            $display("FAIL limits got=%h want=%h", d, x);
        end
        show(6'h00, 127, 255, 3, d);
        x = {BL, BL, BL, DS, DS, BL, BL, BL};
        total++;
        if (d !== x) begin
            bad++;
            $display("FAIL state00 got=%h want=%h", d, x);
        end
    endtask

    task automatic test_states();
        logic [55:0] d;
        logic [55:0] x;
        show(6'h01, 50, 60, 70, d);
        x = {BL, BL, BL, S0, S1, BL, BL, BL};
        total++;
        if (d !== x) begin
            bad++;
            $display("FAIL idle got=%h want=%h", d, x);
        end
        show(6'h20, 0, 33, 100, d);
        x = {BL, BL, S0, S2, S0, S1, S0, S0};
        total++;
        if (d !== x) begin
            bad++;
            $display("FAIL temp got=%h want=%h", d, x);
        end
        show(6'h02, 9, 0, 44, d);
        x = {BL, BL, S9, S0, S2, BL, BL, S0};
        total++;
        if (d !== x) begin
            bad++;
            $display("FAIL goods_one got=%h want=%h", d, x);
        end
        show(6'h03, 9, 0, 44, d);
        x = {BL, BL, BL, DS, DS, BL, BL, BL};
        total++;
        if (d !== x) begin
            bad++;
            $display("FAIL two_hot got=%h want=%h", d, x);
        end
    endtask

    task automatic test_scan();
        logic [7:0] x;
        reset_dut();
        for (int e = 1; e <= 70; e++) begin
            @(posedge sys_clk);
            #1;
            x = ~(8'd1 << (((e - 1) / 4) % 8));
            total++;
            if (an !== x) begin
                bad++;
                $display("FAIL scan_an e=%0d got=%h want=%h", e, an, x);
            end
        end
    endtask

    task automatic test_snapshot();
        set_in(6'h08, 0, 5, 0);
        reset_dut();
        repeat (4) @(posedge sys_clk);
        #1;
        input_money = 8'd99;
        repeat (29) @(posedge sys_clk);
        #1;
        total++;
        if (an !== 8'hFE || seg !== S5) begin
            bad++;
            $display("FAIL snap_old_units got=%h/%h want=fe/%h", an, seg, S5);
        end
        repeat (4) @(posedge sys_clk);
        #1;
        total++;
        if (an !== 8'hFD || seg !== BL) begin
            bad++;
            $display("FAIL snap_old_tens got=%h/%h want=fd/%h", an, seg, BL);
        end
        repeat (28) @(posedge sys_clk);
        #1;
        total++;
        if (an !== 8'hFE || seg !== S9) begin
            bad++;
            $display("FAIL snap_new_units got=%h/%h want=fe/%h", an, seg, S9);
        end
        repeat (4) @(posedge sys_clk);
        #1;
        total++;
        if (an !== 8'hFD || seg !== S9) begin
            bad++;
            $display("FAIL snap_new_tens got=%h/%h want=fd/%h", an, seg, S9);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        sys_rst_n = 1'b0;
        set_in(6'h01, 0, 0, 0);
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        test_reset();
        test_payment();
        test_change();
        test_limits();
        test_states();
        test_scan();
        test_snapshot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
